// File: rtl/control_unit_fsm_if.sv
// Handshake/control bundle between the multicycle control unit and the PC/memory/datapath top level.
// The master side is the control unit; the slave side is the datapath it steers.
interface control_unit_fsm_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 halt_req;
    logic [31:0]          instruction;
    logic                 sub;
    logic                 WE_RF;
    logic                 WE_MEM;
    logic                 RF_din_sel;
    logic                 ULA_din2_sel;
    logic                 load_pc;
    logic                 reset_pc;
    logic                 busy;
    logic                 trap;
    logic [CNT_WIDTH-1:0] retired;
    logic [2:0]           state;

    modport master (
        input  start, halt_req, instruction,
        output sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc,
               busy, trap, retired, state
    );

    modport slave (
        output start, halt_req, instruction,
        input  sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc,
               busy, trap, retired, state
    );
endinterface

// File: rtl/control_unit_fsm.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the add/sub/addi/lw/sw subset.
// Outputs are decoded from the state and the instruction class captured in FETCH.
module control_unit_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                CLK,
    input  logic                RST,
    control_unit_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6,
        SPARE  = 3'd7
    } state_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] retired_q;

    // Instruction class register; funct7 is kept as bit 5 plus an "all other bits zero" flag
    logic [6:0]           cls_opcode;
    logic [2:0]           cls_funct3;
    logic                 cls_f7b5;
    logic                 cls_f7_rest_zero;

    logic                 is_r;
    logic                 is_addi;
    logic                 is_lw;
    logic                 is_sw;
    logic                 legal;
    logic                 retire;
    logic                 alu_en;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cls_opcode       <= '0;
            cls_funct3       <= '0;
            cls_f7b5         <= 1'b0;
            cls_f7_rest_zero <= 1'b0;
        end else if (state_q == FETCH) begin
            cls_opcode       <= bus.instruction[6:0];
            cls_funct3       <= bus.instruction[14:12];
            cls_f7b5         <= bus.instruction[30];
            cls_f7_rest_zero <= (bus.instruction[31] == 1'b0) && (bus.instruction[29:25] == 5'd0);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_ONE;
        end
    end

    always_comb begin
        is_r    = (cls_opcode == OPC_R) && (cls_funct3 == 3'b000) && cls_f7_rest_zero;
        is_addi = (cls_opcode == OPC_ADDI) && (cls_funct3 == 3'b000);
        is_lw   = (cls_opcode == OPC_LW) && (cls_funct3 == 3'b010);
        is_sw   = (cls_opcode == OPC_SW) && (cls_funct3 == 3'b010);
        legal   = is_r || is_addi || is_lw || is_sw;
    end

    always_comb begin
        state_d         = state_q;
        retire          = 1'b0;
        alu_en          = 1'b0;
        bus.WE_RF       = 1'b0;
        bus.WE_MEM      = 1'b0;
        bus.RF_din_sel  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                state_d = legal ? EXEC : TRAP;
            end
            EXEC: begin
                alu_en  = 1'b1;
                state_d = (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
                alu_en = 1'b1;
                if (is_sw) begin
                    bus.WE_MEM = 1'b1;
                    retire     = 1'b1;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                alu_en         = 1'b1;
                bus.WE_RF      = 1'b1;
                bus.RF_din_sel = is_lw;
                retire         = 1'b1;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // halt_req only matters in the retire cycle
        if (retire) state_d = bus.halt_req ? IDLE : FETCH;
    end

    always_comb begin
        bus.sub          = alu_en && is_r && cls_f7b5;
        bus.ULA_din2_sel = alu_en && (is_addi || is_lw || is_sw);
        bus.load_pc      = retire;
        // Gated by RST so the PC clear cannot leak out while reset is held with start high
        bus.reset_pc     = (state_q == IDLE) && bus.start && !RST;
        bus.busy         = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC) ||
                           (state_q == MEM) || (state_q == WB);
        bus.trap         = (state_q == TRAP);
        bus.retired      = retired_q;
        bus.state        = state_q;
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomized bench for control_unit_fsm: per-instruction expected cycle scripts derived from
// the instruction class, compared every cycle against state, strobes and the retire counter.
module tb_control_unit_fsm;

    localparam int CW = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [8:0] O_SUB   = 9'h100;
    localparam logic [8:0] O_WERF  = 9'h080;
    localparam logic [8:0] O_WEMEM = 9'h040;
    localparam logic [8:0] O_RFSEL = 9'h020;
    localparam logic [8:0] O_ULA   = 9'h010;
    localparam logic [8:0] O_LDPC  = 9'h008;
    localparam logic [8:0] O_RSTPC = 9'h004;
    localparam logic [8:0] O_BUSY  = 9'h002;
    localparam logic [8:0] O_TRAP  = 9'h001;

    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_ILL = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    control_unit_fsm_if #(.CNT_WIDTH(CW)) cu_if();

    control_unit_fsm #(.CNT_WIDTH(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (cu_if)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_ret;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] outs();
        return {cu_if.sub, cu_if.WE_RF, cu_if.WE_MEM, cu_if.RF_din_sel, cu_if.ULA_din2_sel,
                cu_if.load_pc, cu_if.reset_pc, cu_if.busy, cu_if.trap};
    endfunction

    task automatic check_all(input string tag, input logic [2:0] st, input logic [8:0] o);
        check_val({tag, "_state"}, 32'(cu_if.state), 32'(st));
        check_val({tag, "_outs"}, 32'(outs()), 32'(o));
        check_val({tag, "_retired"}, 32'(cu_if.retired), 32'(exp_ret));
    endtask

    // One clock cycle: check at the falling edge, then re-randomize the ignorable inputs
    task automatic cyc(input logic [2:0] st, input logic [8:0] o, input string tag);
        @(negedge CLK);
        check_all(tag, st, o);
        @(posedge CLK);
        #1;
        cu_if.start    = 1'($urandom);
        cu_if.halt_req = 1'($urandom);
    endtask

    function automatic int classify(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        if (op == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) return K_R;
        if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
        if (op == 7'h03 && f3 == 3'd2) return K_LW;
        if (op == 7'h23 && f3 == 3'd2) return K_SW;
        return K_ILL;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 3))
            0:       return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            1:       return {imm, rs1, 3'b000, rd, 7'h13};
            2:       return {imm, rs1, 3'b010, rd, 7'h03};
            default: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
        endcase
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] r;
        logic [2:0]  f3nz;
        r    = $urandom;
        f3nz = 3'($urandom_range(1, 7));
        case ($urandom_range(0, 6))
            0:       r = {7'h01, r[24:15], 3'b000, r[11:7], 7'h33};
            1:       r = {7'h20, r[24:15], f3nz, r[11:7], 7'h33};
            2:       r = {r[31:15], f3nz, r[11:7], 7'h13};
            3:       r = {r[31:15], 3'b000, r[11:7], 7'h03};
            4:       r = {r[31:15], 3'b011, r[11:7], 7'h23};
            5:       r = 32'hFFFF_FFFF;
            default: r = {r[31:7], 7'h7F};
        endcase
        if (classify(r) != K_ILL) r = 32'hFFFF_FFFF;
        return r;
    endfunction

    // hmode: 0 = no halt at retire, 1 = halt at retire, 2 = random
    // status: 0 = next is FETCH, 1 = halted to IDLE, 2 = trapped
    task automatic run_instr(input logic [31:0] ins, input int hmode, output int status);
        int         k;
        logic [8:0] alu;
        logic       h;
        k      = classify(ins);
        status = 0;
        cu_if.instruction = ins;
        cyc(S_FETCH, O_BUSY, "fetch");
        cu_if.instruction = $urandom;
        cyc(S_DECODE, O_BUSY, "decode");
        if (k == K_ILL) begin
            repeat (2) cyc(S_TRAP, O_TRAP, "trap");
            cu_if.start = 1'b1;
            repeat (2) cyc(S_TRAP, O_TRAP, "trap_start");
            status = 2;
            return;
        end
        alu = ((k != K_R) ? O_ULA : 9'h000) | ((k == K_R && ins[30]) ? O_SUB : 9'h000);
        cu_if.instruction = $urandom;
        cyc(S_EXEC, O_BUSY | alu, "exec");
        if (k == K_LW) begin
            cyc(S_MEM, O_BUSY | alu, "mem_lw");
        end
        if (hmode == 0) cu_if.halt_req = 1'b0;
        if (hmode == 1) cu_if.halt_req = 1'b1;
        h = cu_if.halt_req;
        if (k == K_SW) begin
            cyc(S_MEM, O_BUSY | alu | O_WEMEM | O_LDPC, "mem_sw");
        end else begin
            cyc(S_WB, O_BUSY | alu | O_WERF | O_LDPC | ((k == K_LW) ? O_RFSEL : 9'h000), "wb");
        end
        exp_ret = exp_ret + 1'b1;
        status  = h ? 1 : 0;
    endtask

    // Sit in IDLE for a few cycles, then pulse start for one cycle
    task automatic launch(input int idle_cycles);
        repeat (idle_cycles) begin
            cu_if.start = 1'b0;
            cyc(S_IDLE, 9'h000, "idle");
        end
        cu_if.start = 1'b1;
        cyc(S_IDLE, O_RSTPC, "idle_start");
    endtask

    // Asynchronous reset pulse in the middle of a cycle; leaves start high so FETCH follows
    task automatic pulse_reset();
        #2;
        RST         = 1'b1;
        cu_if.start = 1'b1;
        exp_ret     = '0;
        #1;
        check_all("rst_async", S_IDLE, 9'h000);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_all("rst_exit", S_IDLE, O_RSTPC);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        exp_ret           = '0;
        cu_if.start       = 1'b1;
        cu_if.halt_req    = 1'b0;
        cu_if.instruction = 32'h0;
        #1;
        RST = 1'b1;
        #1;
        check_all("reset", S_IDLE, 9'h000);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all("reset_hold", S_IDLE, 9'h000);
        cu_if.start = 1'b0;
        RST         = 1'b0;
        @(posedge CLK);
        #1;

        launch(2);
        run_instr(32'h0050_0093, 0, st);
        run_instr(32'h0020_81B3, 0, st);
        run_instr(32'h4020_81B3, 0, st);
        run_instr(32'h0000_2283, 0, st);
        run_instr(32'h0050_2223, 1, st);
        launch(1);

        cu_if.instruction = 32'h0050_0093;
        cyc(S_FETCH, O_BUSY, "pre_fetch");
        cyc(S_DECODE, O_BUSY, "pre_decode");
        pulse_reset();

        for (int n = 0; n < 80; n++) begin
            run_instr(rand_legal(), 2, st);
            if (st == 1) launch($urandom_range(0, 2));
        end

        for (int t = 0; t < 8; t++) begin
            run_instr(rand_legal(), 0, st);
            run_instr(rand_illegal(), 0, st);
            pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
